// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state type and byte-enable helpers
// for the memory-stage data access unit and its load formatter.
`default_nettype none

package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } dmem_state_t;

  // Access size is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   be_for = BE_BYTE << lane;
      2'b01:   be_for = BE_HALF << {lane[1], 1'b0};
      default: be_for = BE_WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_format.sv
// load_format: selects the addressed byte/half lane of a read word and
// sign- or zero-extends it according to the load funct3.
`default_nettype none

module load_format
  import dmem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LW:   o_result = i_rdata;
      F3_LBU:  o_result = {24'd0, w_byte};
      F3_LHU:  o_result = {16'd0, w_half};
      default: o_result = 32'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: M-stage load/store unit driving a req/gnt/rvalid data bus,
// stalling the pipeline while a transaction is outstanding.
`default_nettype none

module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMemM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] c_LIMIT = 8'(MAX_WAIT - 1);

  dmem_state_t r_state, w_next;
  logic        w_access, w_f3_ok, w_misal, w_legal, w_expired, w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_fmt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic [31:0] r_rdata, r_bus_addr, r_bus_wdata;
  logic [3:0]  r_bus_be;
  logic        r_bus_req, r_bus_we, r_buserr;

  assign w_access = MemReadM | MemWriteM;

  always_comb begin
    w_f3_ok = 1'b0;
    if (MemReadM && !MemWriteM)
      w_f3_ok = (Funct3M == F3_LB) || (Funct3M == F3_LH) || (Funct3M == F3_LW) ||
                (Funct3M == F3_LBU) || (Funct3M == F3_LHU);
    else if (MemWriteM && !MemReadM)
      w_f3_ok = (Funct3M == F3_SB) || (Funct3M == F3_SH) || (Funct3M == F3_SW);
  end

  assign w_misal = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                   ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
  assign w_legal = w_access && w_f3_ok && !w_misal;
  assign w_be    = be_for(Funct3M[1:0], ALUResultM[1:0]);

  always_comb begin
    case (Funct3M[1:0])
      2'b00:   w_wdata = {4{WriteDataM[7:0]}};
      2'b01:   w_wdata = {2{WriteDataM[15:0]}};
      default: w_wdata = WriteDataM;
    endcase
  end

  assign w_expired = (r_cnt >= c_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // A grant or rvalid in the same cycle as expiry wins over the timeout.
  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    case (r_state)
      IDLE: if (w_legal) w_next = REQ;
      REQ: begin
        if (bus_gnt)        w_next = r_bus_we ? RESP : WAIT;
        else if (w_expired) begin w_next = RESP; w_tmo = 1'b1; end
      end
      WAIT: begin
        if (bus_rvalid)     w_next = RESP;
        else if (w_expired) begin w_next = RESP; w_tmo = 1'b1; end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 8'd0;
      r_f3        <= 3'd0;
      r_lane      <= 2'd0;
      r_rdata     <= 32'd0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_buserr    <= 1'b0;
    end else begin
      r_bus_req <= (w_next == REQ);
      r_buserr  <= w_tmo;
      if (r_state == IDLE)
        r_cnt <= 8'd0;
      else if (r_state == REQ || r_state == WAIT)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == IDLE && w_legal) begin
        r_f3        <= Funct3M;
        r_lane      <= ALUResultM[1:0];
        r_bus_we    <= MemWriteM;
        r_bus_addr  <= {ALUResultM[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_wdata;
      end
      if (r_state == WAIT && bus_rvalid)
        r_rdata <= bus_rdata;
    end
  end

  load_format u_load_format (
    .i_rdata  (r_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_f3),
    .o_result (w_fmt)
  );

  // Gating with reset keeps stall/misalign low while reset is held, even
  // if the pipeline still presents an access.
  assign StallMemM = reset && (((r_state == IDLE) && w_legal) || (r_state == REQ) || (r_state == WAIT));
  assign MisalignM = reset && (r_state == IDLE) && w_access && !w_legal;
  assign BusErrM   = (r_state == RESP) && r_buserr;
  assign ReadDataM = ((r_state == RESP) && !r_buserr) ? w_fmt : 32'd0;

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed self-checking bench for dmem_access_unit.
`default_nettype none

module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMemM, MisalignM, BusErrM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;

  dmem_access_unit #(.MAX_WAIT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallMemM  (StallMemM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] rd, input logic [3:0] ebe, input logic [31:0] eres);
    MemReadM = 1'b1; Funct3M = f3; ALUResultM = a;
    #1;
    check({tag, ".stall_idle"}, 32'(StallMemM), 32'd1);
    check({tag, ".req_idle"}, 32'(bus_req), 32'd0);
    step();
    check({tag, ".req"}, 32'(bus_req), 32'd1);
    check({tag, ".we"}, 32'(bus_we), 32'd0);
    check({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
    check({tag, ".be"}, 32'(bus_be), 32'(ebe));
    check({tag, ".stall_req"}, 32'(StallMemM), 32'd1);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check({tag, ".req_wait"}, 32'(bus_req), 32'd0);
    check({tag, ".stall_wait"}, 32'(StallMemM), 32'd1);
    bus_rvalid = 1'b1; bus_rdata = rd;
    step();
    bus_rvalid = 1'b0; bus_rdata = 32'h5A5A_5A5A;
    check({tag, ".stall_resp"}, 32'(StallMemM), 32'd0);
    check({tag, ".rdata"}, ReadDataM, eres);
    check({tag, ".buserr"}, 32'(BusErrM), 32'd0);
    MemReadM = 1'b0;
    step();
    check({tag, ".rdata_after"}, ReadDataM, 32'd0);
    check({tag, ".stall_after"}, 32'(StallMemM), 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [3:0] ebe, input logic [31:0] ewd);
    MemWriteM = 1'b1; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
    #1;
    check({tag, ".stall_idle"}, 32'(StallMemM), 32'd1);
    step();
    check({tag, ".req"}, 32'(bus_req), 32'd1);
    check({tag, ".we"}, 32'(bus_we), 32'd1);
    check({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
    check({tag, ".be"}, 32'(bus_be), 32'(ebe));
    check({tag, ".wdata"}, bus_wdata, ewd);
    check({tag, ".stall_req"}, 32'(StallMemM), 32'd1);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check({tag, ".stall_resp"}, 32'(StallMemM), 32'd0);
    check({tag, ".req_resp"}, 32'(bus_req), 32'd0);
    MemWriteM = 1'b0;
    step();
    check({tag, ".stall_after"}, 32'(StallMemM), 32'd0);
  endtask

  task automatic do_bad(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a);
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a;
    #1;
    check({tag, ".misalign"}, 32'(MisalignM), 32'd1);
    check({tag, ".stall"}, 32'(StallMemM), 32'd0);
    check({tag, ".rdata"}, ReadDataM, 32'd0);
    step();
    check({tag, ".req"}, 32'(bus_req), 32'd0);
    MemReadM = 1'b0; MemWriteM = 1'b0;
    #1;
    check({tag, ".misalign_clr"}, 32'(MisalignM), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
    ALUResultM = 32'd0; WriteDataM = 32'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
    #3;
    check("rst.rdata", ReadDataM, 32'd0);
    check("rst.stall", 32'(StallMemM), 32'd0);
    check("rst.misalign", 32'(MisalignM), 32'd0);
    check("rst.buserr", 32'(BusErrM), 32'd0);
    check("rst.req", 32'(bus_req), 32'd0);
    check("rst.addr", bus_addr, 32'd0);
    check("rst.be", 32'(bus_be), 32'd0);
    step();
    step();
    reset = 1'b1;
    step();

    do_load("lw100", 32'h0000_0100, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    do_load("lb103", 32'h0000_0103, 3'b000, 32'h8012_3456, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu103", 32'h0000_0103, 3'b100, 32'h8012_3456, 4'b1000, 32'h0000_0080);
    do_load("lhu102", 32'h0000_0102, 3'b101, 32'hF00D_1234, 4'b1100, 32'h0000_F00D);
    do_load("lh100", 32'h0000_0100, 3'b001, 32'h1234_8001, 4'b0011, 32'hFFFF_8001);
    do_load("lb101", 32'h0000_0101, 3'b000, 32'h0000_7F00, 4'b0010, 32'h0000_007F);

    do_store("sb201", 32'h0000_0201, 3'b000, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    do_store("sh202", 32'h0000_0202, 3'b001, 32'hCAFE_1234, 4'b1100, 32'h1234_1234);
    do_store("sw204", 32'h0000_0204, 3'b010, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    do_bad("mis_lw102", 1'b1, 1'b0, 3'b010, 32'h0000_0102);
    do_bad("ill_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100);
    do_bad("mis_sh201", 1'b0, 1'b1, 3'b001, 32'h0000_0201);
    do_bad("ill_rdwr", 1'b1, 1'b1, 3'b010, 32'h0000_0100);
    do_bad("ill_sbu", 1'b0, 1'b1, 3'b100, 32'h0000_0100);

    // Bus timeout: no grant ever arrives.
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0300;
    step();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("tmo.req%0d", i), 32'(bus_req), 32'd1);
      check($sformatf("tmo.stall%0d", i), 32'(StallMemM), 32'd1);
      step();
    end
    check("tmo.buserr", 32'(BusErrM), 32'd1);
    check("tmo.rdata", ReadDataM, 32'd0);
    check("tmo.stall_resp", 32'(StallMemM), 32'd0);
    check("tmo.req_resp", 32'(bus_req), 32'd0);
    MemReadM = 1'b0;
    step();
    check("tmo.buserr_clr", 32'(BusErrM), 32'd0);

    // Reset while in REQ drops bus_req immediately.
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0400;
    step();
    check("rstreq.req_before", 32'(bus_req), 32'd1);
    reset = 1'b0;
    #1;
    check("rstreq.req", 32'(bus_req), 32'd0);
    check("rstreq.stall", 32'(StallMemM), 32'd0);
    step();
    reset = 1'b1;
    MemReadM = 1'b0;
    step();

    // Reset while in WAIT.
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_0404;
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check("rstwait.stall_before", 32'(StallMemM), 32'd1);
    reset = 1'b0;
    #1;
    check("rstwait.req", 32'(bus_req), 32'd0);
    check("rstwait.stall", 32'(StallMemM), 32'd0);
    check("rstwait.rdata", ReadDataM, 32'd0);
    check("rstwait.addr", bus_addr, 32'd0);
    step();
    check("rstwait.stall_held", 32'(StallMemM), 32'd0);
    MemReadM = 1'b0;
    reset = 1'b1;
    step();

    do_load("lw_post_rst", 32'h0000_0500, 3'b010, 32'h1234_5678, 4'b1111, 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data-memory access unit sitting between the pipelined datapath's M stage (address from `ALUResultM`, store data from `WriteDataM`) and a request/grant/response data-memory bus. It converts RV32I load/store `funct3` into byte enables and lane-replicated write data. It runs a multi-cycle bus handshake, returning the aligned and sign/zero-extended `ReadDataM` to the M/W pipeline register. While a transaction is outstanding it freezes the whole pipeline through `StallMemM`. It flags misaligned or illegal accesses and bus timeouts.

## Interface

- `MAX_WAIT`, default 15: cycles allowed in REQ+WAIT before a bus timeout; range 1–255.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; 0 = reset asserted.
- `MemReadM`  in  1  load in M stage.
- `MemWriteM`  in  1  store in M stage.
- `Funct3M`  in  3  instruction funct3.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  store source register value.
- `ReadDataM`  out  32  formatted load data; valid in the RESP cycle.
- `StallMemM`  out  1  freeze PC, F/D, D/E, E/M, M/W registers.
- `MisalignM`  out  1  one-cycle pulse: misaligned or illegal access, no bus activity.
- `BusErrM`  out  1  one-cycle pulse in RESP on timeout.
- `bus_req`  out  1  request valid.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address, bits [1:0] = 0.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  write data.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  read data valid.
- `bus_rdata`  in  32  read data.

## Operation

- Access is `MemReadM | MemWriteM`. If both are high, the access is illegal.
- Legal loads: `funct3` 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal stores: `funct3` 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misaligned: half with `addr[0]`=1; word with `addr[1:0]`≠0.
- Byte enables:
  - byte: `be` = 0001<<`addr[1:0]`.
  - half: `be` = 0011<<(2·`addr[1]`).
  - word: `be` = 1111.
- Write data: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word unchanged.
- Load format: select the lane by `addr[1:0]`. Signed codes sign-extend, unsigned codes zero-extend.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE: a legal access latches addr/we/be/wdata/funct3/addr[1:0], goes to REQ, and raises `StallMemM` combinationally this cycle. An illegal or misaligned access pulses `MisalignM`, produces no stall and no bus activity, and drives `ReadDataM`=0.
  - REQ: `bus_req`=1 with stable latched fields. On `bus_gnt`, a store goes to RESP and a load goes to WAIT.
  - WAIT: on `bus_rvalid`, capture `bus_rdata` and go to RESP. `bus_rvalid` is sampled only in WAIT.
  - RESP: `StallMemM`=0; `ReadDataM` = formatted captured data; the pipeline advances at this edge. Always goes to IDLE; the instruction present in IDLE on the next cycle is new.
- `StallMemM` = (IDLE & legal access) | REQ | WAIT.
- Timeout: an 8-bit wait counter clears on entry to REQ and increments in REQ/WAIT. When it reaches `MAX_WAIT`, go to RESP with `BusErrM`=1, `ReadDataM`=0, and `bus_req` dropped.

## Timing

- Reset (async, `reset`=0) values:
  - state IDLE, all bus outputs 0, counter 0.
  - `ReadDataM`=0, `StallMemM`=0, `MisalignM`=0, `BusErrM`=0.
- Reset mid-transaction: state returns to IDLE and `bus_req` falls immediately; no response is delivered.
- Minimum latency (grant in the first REQ cycle, rvalid in the first WAIT cycle):
  - load: 4 cycles in M (3 stalled).
  - store: 3 cycles in M (2 stalled).
- Bus outputs are registered and change only on state entry.

## Structure

- Package `dmem_pkg` holds:
  - `funct3` localparams (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the `dmem_state_t` enum {IDLE, REQ, WAIT, RESP};
  - BE constants.
- One combinational sub-module, `load_format` (rdata, addr[1:0], funct3 → 32-bit result), is shared with any future instruction-side byte access.

## Test plan

- LW addr 0x100, gnt in first REQ cycle, rvalid next cycle, rdata 0xDEADBEEF → `bus_be`=1111, `bus_addr`=0x100, `ReadDataM`=0xDEADBEEF in cycle 3, `StallMemM` high for cycles 0–2.
- LB addr 0x103, rdata 0x80xxxxxx → `be`=1000, `ReadDataM`=0xFFFFFF80. LBU at the same address → 0x00000080. LHU addr 0x102, rdata 0xF00Dxxxx → 0x0000F00D.
- SB addr 0x201, wd 0x000000AB → `bus_we`=1, `be`=0010, `bus_wdata`=0xABABABAB, 3 cycles in M.
- LW addr 0x102 → `MisalignM` one-cycle pulse, `bus_req` stays 0, `StallMemM` stays 0. `funct3` 011 with `MemReadM` gives the same response.
- `bus_gnt` held 0, `MAX_WAIT`=15 → RESP after 15 cycles in REQ, `BusErrM` pulses, `ReadDataM`=0, stall released.
- `reset`=0 asserted during WAIT → `bus_req`, `StallMemM` and `ReadDataM` go to 0 asynchronously; after release, a new LW completes normally.
